// File: rtl/arb_stream_mux.sv
// N-channel, W-bit stream multiplexer with valid/ready handshakes, an internal arbiter
// and one registered output stage. Define ARB_STREAM_MUX_RR_EN for round-robin; default is fixed priority.
module arb_stream_mux #(
  parameter  int N_CH  = 4,
  parameter  int W     = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  input  logic              out_ready
);

  logic             can_acc;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [N_CH-1:0]  grant;
  logic             in_xfer;

  assign can_acc = !out_valid || out_ready;

`ifdef ARB_STREAM_MUX_RR_EN
  logic [SEL_W-1:0] ptr;

  // Search starts at ptr and wraps explicitly so non-power-of-2 channel counts never index past N_CH-1.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first; a path that skips an assignment infers a latch.
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_vld && in_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (in_xfer) begin
      ptr <= (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  // Scanning downwards lets the lowest valid index overwrite any higher one.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(k);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  assign in_xfer  = gnt_vld && can_acc;
  assign in_ready = (in_xfer && !rst) ? grant : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(gnt_idx)*W +: W];
      out_sel   <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
